// File: rtl/temp_seg_display.sv
// Eight-digit multiplexed seven-segment driver: snapshots two bytes, converts each to BCD
// with a serial double-dabble loop and scans them out. Optional macro: LEADING_ZERO_BLANK_EN.
module temp_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] left_data,
    input  logic [7:0] right_data,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [7:0] AN,
    output logic       bcd_valid
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {CAPTURE, SHIFT, COMMIT} conv_state_e;

    conv_state_e       state_q;
    logic [2:0]        shift_cnt_q;
    logic [DATA_W-1:0] lsh_q, rsh_q;
    logic [BCD_W-1:0]  lbcd_q, rbcd_q;
    logic [BCD_W-1:0]  ldisp_q, rdisp_q;
    logic              valid_q;

    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [7:0]        an_q, an_d;

    logic [3:0]        digit_c;
    logic              pos_blank_c;
    logic              zero_blank_c;
    logic [BCD_W-1:0]  ladj_c, radj_c;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign ladj_c = add3(lbcd_q);
    assign radj_c = add3(rbcd_q);

    // Converter: capture, 8 add-3/shift steps, then atomic commit of all six digits.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= CAPTURE;
            shift_cnt_q <= 3'd0;
            lsh_q       <= '0;
            rsh_q       <= '0;
            lbcd_q      <= '0;
            rbcd_q      <= '0;
            ldisp_q     <= '0;
            rdisp_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                CAPTURE: begin
                    lsh_q       <= left_data;
                    rsh_q       <= right_data;
                    lbcd_q      <= '0;
                    rbcd_q      <= '0;
                    shift_cnt_q <= 3'd0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    lbcd_q      <= {ladj_c[BCD_W-2:0], lsh_q[DATA_W-1]};
                    rbcd_q      <= {radj_c[BCD_W-2:0], rsh_q[DATA_W-1]};
                    lsh_q       <= {lsh_q[DATA_W-2:0], 1'b0};
                    rsh_q       <= {rsh_q[DATA_W-2:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'd7) state_q <= COMMIT;
                end
                COMMIT: begin
                    ldisp_q <= lbcd_q;
                    rdisp_q <= rbcd_q;
                    valid_q <= 1'b1;
                    state_q <= CAPTURE;
                end
                default: state_q <= CAPTURE;
            endcase
        end
    end

    // Digit selection for the current scan position; positions 3 and 7 are dark.
    always_comb begin
        digit_c      = 4'd0;
        pos_blank_c  = 1'b0;
        zero_blank_c = 1'b0;
        case (idx_q)
            3'd0: digit_c = rdisp_q[3:0];
            3'd1: digit_c = rdisp_q[7:4];
            3'd2: digit_c = rdisp_q[11:8];
            3'd4: digit_c = ldisp_q[3:0];
            3'd5: digit_c = ldisp_q[7:4];
            3'd6: digit_c = ldisp_q[11:8];
            default: pos_blank_c = 1'b1;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            3'd1: zero_blank_c = (rdisp_q[11:4] == 8'd0);
            3'd2: zero_blank_c = (rdisp_q[11:8] == 4'd0);
            3'd5: zero_blank_c = (ldisp_q[11:4] == 8'd0);
            3'd6: zero_blank_c = (ldisp_q[11:8] == 4'd0);
            default: zero_blank_c = 1'b0;
        endcase
`endif
        an_d  = pos_blank_c ? 8'hFF : ~(8'd1 << idx_q);
        seg_d = (pos_blank_c || zero_blank_c) ? 7'h7F : seg_code(digit_c);
    end

    // Refresh counter, digit index and registered pin drivers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            seg_q <= 7'h7F;
            an_q  <= 8'hFF;
        end else begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG       = seg_q;
    assign AN        = an_q;
    assign DP        = 1'b1;
    assign bcd_valid = valid_q;

endmodule
